q_span_scheduler: RTL and testbench

- Sequences access to the spline control-point (Q) weight table for one filter instance.
- Accepts sample span indices and issues table reads, holding each span in flight until its weight update returns.
- Issues the write-back span indices (current and one-cycle-delayed) to the Q weight controller.
- Stalls any new read whose 4-entry window overlaps a pending write (read-after-write hazard on control points).

---
 rtl/q_sched_pkg.sv | 23 ++
 rtl/q_span_fifo.sv | 71 +++++++
 rtl/q_span_scheduler.sv | 141 ++++++++++++++
 tb/tb_q_span_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/q_sched_pkg.sv
// Shared constants, state encoding and span-window overlap helper for the
// Q weight-table span scheduler.
package q_sched_pkg;

  localparam int unsigned Q     = 13;
  localparam int unsigned Q_ORD = 4;
  localparam int unsigned IDX_W = $clog2(Q + Q_ORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } q_sched_state_t;

  // Two Q_ORD-wide control-point windows starting at a and b share an entry.
  function automatic logic span_overlap(input logic [IDX_W-1:0] a,
                                        input logic [IDX_W-1:0] b);
    logic [IDX_W-1:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return (diff <= IDX_W'(Q_ORD - 1));
  endfunction

endpackage

// File: rtl/q_span_fifo.sv
// In-flight span queue: DEPTH-entry register FIFO exposing every slot and its
// valid bit so the scheduler can hazard-check all pending spans in parallel.
module q_span_fifo
  import q_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [IDX_W-1:0]                  push_data,
  input  logic                              pop,
  output logic [IDX_W-1:0]                  head,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic [DEPTH-1:0][IDX_W-1:0]       entries,
  output logic [DEPTH-1:0]                  valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][IDX_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head    = vld_q[rd_ptr_q] ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;
  assign entries = mem_q;
  assign valid   = vld_q;

endmodule

// File: rtl/q_span_scheduler.sv
// Q weight-table span scheduler: issues reads, tracks in-flight spans, issues
// write-back spans and stalls on control-point RAW hazards. Q_SCHED_STATS_EN adds stall_cnt.
module q_span_scheduler
  import q_sched_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] span_ind_in,
  input  logic             flush,
  output logic [IDX_W-1:0] span_ind_read,
  output logic             rd_en,
  input  logic             upd_valid,
  output logic [IDX_W-1:0] span_ind_write,
  output logic [IDX_W-1:0] span_ind_write_d,
  output logic             wr_en_d,
  output logic             busy,
  output logic             err_underflow
`ifdef Q_SCHED_STATS_EN
  ,output logic [15:0]     stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  q_sched_state_t state_q, state_d;
  logic [IDX_W-1:0] span_ind_read_q, span_ind_read_d;
  logic             rd_en_q, rd_en_d;
  logic [IDX_W-1:0] span_ind_write_d_q, span_ind_write_d_d;
  logic             wr_en_d_q, wr_en_d_d;
  logic             err_underflow_q, err_underflow_d;

  logic [IDX_W-1:0]                   span_sat;
  logic                               hazard;
  logic                               accept;
  logic                               pop;
  logic                               drained_next;
  logic [CNT_W-1:0]                   occ_next;
  logic [IDX_W-1:0]                   fifo_head;
  logic [CNT_W-1:0]                   fifo_count;
  logic [MAX_INFLIGHT-1:0][IDX_W-1:0] fifo_entries;
  logic [MAX_INFLIGHT-1:0]            fifo_valid;

  q_span_fifo #(
    .DEPTH(MAX_INFLIGHT)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_data(span_sat),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .entries  (fifo_entries),
    .valid    (fifo_valid)
  );

  assign span_sat = (span_ind_in > IDX_W'(Q)) ? IDX_W'(Q) : span_ind_in;

  // Hazard uses pre-pop queue contents so a span matching the popping head
  // stalls until its write-back strobe has passed.
  always_comb begin
    hazard = wr_en_d_q & span_overlap(span_sat, span_ind_write_d_q);
    for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
      if (fifo_valid[i] && span_overlap(span_sat, fifo_entries[i])) hazard = 1'b1;
    end
  end

  assign in_ready = (fifo_count < CNT_W'(MAX_INFLIGHT)) && !hazard && (state_q != FLUSH);
  assign accept   = in_valid & in_ready;
  assign pop      = upd_valid & (fifo_count != '0);

  always_comb begin
    occ_next = fifo_count;
    if (accept && !pop) occ_next = fifo_count + CNT_W'(1);
    if (pop && !accept) occ_next = fifo_count - CNT_W'(1);
    drained_next = (occ_next == '0) && !pop;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (flush) state_d = FLUSH;
               else if (drained_next) state_d = IDLE;
      FLUSH:   if (drained_next) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    span_ind_read_d    = accept ? span_sat : span_ind_read_q;
    rd_en_d            = accept;
    span_ind_write_d_d = pop ? fifo_head : span_ind_write_d_q;
    wr_en_d_d          = pop;
    err_underflow_d    = err_underflow_q | (upd_valid & (fifo_count == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      span_ind_read_q    <= '0;
      rd_en_q            <= 1'b0;
      span_ind_write_d_q <= '0;
      wr_en_d_q          <= 1'b0;
      err_underflow_q    <= 1'b0;
    end else begin
      state_q            <= state_d;
      span_ind_read_q    <= span_ind_read_d;
      rd_en_q            <= rd_en_d;
      span_ind_write_d_q <= span_ind_write_d_d;
      wr_en_d_q          <= wr_en_d_d;
      err_underflow_q    <= err_underflow_d;
    end
  end

  assign span_ind_read    = span_ind_read_q;
  assign rd_en            = rd_en_q;
  assign span_ind_write   = fifo_head;
  assign span_ind_write_d = span_ind_write_d_q;
  assign wr_en_d          = wr_en_d_q;
  assign busy             = (state_q != IDLE);
  assign err_underflow    = err_underflow_q;

`ifdef Q_SCHED_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (state_q != FLUSH) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_q_span_scheduler.sv
// Scoreboard bench for q_span_scheduler: a behavioural model predicts
// in_ready/state; expected read and write-back spans are queued and compared.
module tb_q_span_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] span_ind_in;
  logic       flush;
  logic [4:0] span_ind_read;
  logic       rd_en;
  logic       upd_valid;
  logic [4:0] span_ind_write;
  logic [4:0] span_ind_write_d;
  logic       wr_en_d;
  logic       busy;
  logic       err_underflow;

  q_span_scheduler #(.MAX_INFLIGHT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .span_ind_in     (span_ind_in),
    .flush           (flush),
    .span_ind_read   (span_ind_read),
    .rd_en           (rd_en),
    .upd_valid       (upd_valid),
    .span_ind_write  (span_ind_write),
    .span_ind_write_d(span_ind_write_d),
    .wr_en_d         (wr_en_d),
    .busy            (busy),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int mq[$];
  int exp_rd[$];
  int exp_wr[$];
  bit m_wr_pend;
  int m_wr_val;
  bit m_err;
  int m_state;      // 0 idle, 1 busy, 2 flush
  int m_last_read;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic do_reset();
    #2;
    reset       = 1'b1;
    in_valid    = 1'b0;
    span_ind_in = '0;
    upd_valid   = 1'b0;
    flush       = 1'b0;
    #1;
    check_val("rst_rd_en", rd_en, 0);
    check_val("rst_wr_en_d", wr_en_d, 0);
    check_val("rst_span_read", span_ind_read, 0);
    check_val("rst_span_write_d", span_ind_write_d, 0);
    check_val("rst_span_write", span_ind_write, 0);
    check_val("rst_err", err_underflow, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_busy", busy, 0);
    mq.delete(); exp_rd.delete(); exp_wr.delete();
    m_wr_pend = 0; m_wr_val = 0; m_err = 0; m_state = 0; m_last_read = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock of stimulus, called at a negedge.
  task automatic step(input bit v, input int span, input bit upd, input bit fl);
    int  s;
    bit  haz, exp_ready, acc, pop, drained;
    logic [31:0] sp;
    sp          = span;
    in_valid    = v;
    span_ind_in = sp[4:0];
    upd_valid   = upd;
    flush       = fl;
    #1;
    s   = (span > 13) ? 13 : span;
    haz = m_wr_pend && (absd(s, m_wr_val) <= 3);
    foreach (mq[i]) if (absd(s, mq[i]) <= 3) haz = 1;
    exp_ready = (mq.size() < 4) && !haz && (m_state != 2);
    check_val("in_ready", in_ready, exp_ready);
    acc = v && exp_ready;
    pop = upd && (mq.size() > 0);
    if (upd && mq.size() == 0) m_err = 1;
    if (acc) exp_rd.push_back(s);
    if (pop) begin
      exp_wr.push_back(mq[0]);
      m_wr_val = mq.pop_front();
    end
    m_wr_pend = pop;
    if (acc) begin
      mq.push_back(s);
      m_last_read = s;
    end
    drained = (mq.size() == 0) && !m_wr_pend;
    case (m_state)
      0: if (acc) m_state = 1;
      1: if (fl) m_state = 2; else if (drained) m_state = 0;
      default: if (drained) m_state = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
    check_val("rd_en", rd_en, acc);
    if (rd_en && exp_rd.size() > 0) check_val("rd_span", span_ind_read, exp_rd.pop_front());
    check_val("span_read_hold", span_ind_read, m_last_read);
    check_val("wr_en_d", wr_en_d, pop);
    if (wr_en_d && exp_wr.size() > 0) check_val("wr_span_d", span_ind_write_d, exp_wr.pop_front());
    check_val("span_write_head", span_ind_write, (mq.size() > 0) ? mq[0] : 0);
    check_val("busy", busy, m_state != 0);
    check_val("err_underflow", err_underflow, m_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; span_ind_in = '0; upd_valid = 0; flush = 0;
    do_reset();

    // Basic accept, overlap stall, non-overlap accept, drain
    step(1, 5, 0, 0);
    step(1, 7, 0, 0);
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Span equal-ish to popping head stalls two cycles, then accepted
    do_reset();
    step(1, 5, 0, 0);
    step(1, 6, 1, 0);
    step(1, 6, 0, 0);
    step(1, 6, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Fill to capacity, saturated 16 -> 13 stalls on full then on hazard
    do_reset();
    step(1, 0, 0, 0);
    step(1, 4, 0, 0);
    step(1, 8, 0, 0);
    step(1, 12, 0, 0);
    step(1, 16, 0, 0);
    step(1, 16, 1, 0);
    step(1, 16, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Saturation on empty queue
    do_reset();
    step(1, 20, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Underflow is sticky and does not raise wr_en_d
    do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Flush drains two entries then returns to idle
    do_reset();
    step(1, 2, 0, 0);
    step(1, 8, 0, 0);
    step(0, 0, 0, 1);
    step(1, 13, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 13, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Reset asserted mid-flush
    step(1, 2, 0, 0);
    step(1, 8, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    do_reset();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 20)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
